// File: rtl/cell_drawer.sv
// cell_drawer: rasterises one board cell into a one-pixel-per-cycle VGA plot stream,
// with a one-entry pending request buffer. Define CELL_DRAWER_GRID_EN for 13x13 cells with grid lines.
module cell_drawer #(
  parameter logic [2:0] BG_COLOUR = 3'b010
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] x_plot,
  input  logic [6:0] y_plot,
  input  logic [1:0] select,
  input  logic       enable,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

`ifdef CELL_DRAWER_GRID_EN
  localparam int   N    = 13;
  localparam logic GRID = 1'b1;
`else
  localparam int   N    = 12;
  localparam logic GRID = 1'b0;
`endif
  localparam logic [3:0] LAST = 4'(N - 1);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t     state, state_nx;
  logic [3:0] cx, cy, cx_nx, cy_nx;
  logic [7:0] act_x, act_x_nx, pend_x, pend_x_nx;
  logic [6:0] act_y, act_y_nx, pend_y, pend_y_nx;
  logic [1:0] act_sel, act_sel_nx, pend_sel, pend_sel_nx;
  logic       pend_vld, pend_vld_nx;
  logic       drop;

  // Disk is the 8x8 block at 2..9 with its four corner pixels knocked out.
  function automatic logic [2:0] pixel_colour(input logic [3:0] px, input logic [3:0] py,
                                              input logic [1:0] sel);
    logic in_box, corner;
    in_box = (px >= 4'd2) && (px <= 4'd9) && (py >= 4'd2) && (py <= 4'd9);
    corner = ((px == 4'd2) || (px == 4'd9)) && ((py == 4'd2) || (py == 4'd9));
    if (GRID && ((px == 4'd12) || (py == 4'd12))) return 3'b000;
    if (in_box && !corner && (sel == 2'd2)) return 3'b000;
    if (in_box && !corner && (sel == 2'd3)) return 3'b111;
    return BG_COLOUR;
  endfunction

  always_comb begin
    state_nx    = state;
    cx_nx       = cx;
    cy_nx       = cy;
    act_x_nx    = act_x;
    act_y_nx    = act_y;
    act_sel_nx  = act_sel;
    pend_x_nx   = pend_x;
    pend_y_nx   = pend_y;
    pend_sel_nx = pend_sel;
    pend_vld_nx = pend_vld;
    drop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          act_x_nx   = x_plot;
          act_y_nx   = y_plot;
          act_sel_nx = select;
          cx_nx      = 4'd0;
          cy_nx      = 4'd0;
          state_nx   = DRAW;
        end
      end
      DRAW: begin
        if (enable) begin
          if (pend_vld) begin
            drop = 1'b1;
          end else begin
            pend_vld_nx = 1'b1;
            pend_x_nx   = x_plot;
            pend_y_nx   = y_plot;
            pend_sel_nx = select;
          end
        end
        if (cx == LAST) begin
          cx_nx = 4'd0;
          if (cy == LAST) begin
            cy_nx    = 4'd0;
            state_nx = DONE;
          end else begin
            cy_nx = cy + 4'd1;
          end
        end else begin
          cx_nx = cx + 4'd1;
        end
      end
      DONE: begin
        cx_nx = 4'd0;
        cy_nx = 4'd0;
        if (pend_vld) begin
          // A strobe in this cycle refills the slot being drained, so it is not dropped.
          act_x_nx   = pend_x;
          act_y_nx   = pend_y;
          act_sel_nx = pend_sel;
          state_nx   = DRAW;
          if (enable) begin
            pend_x_nx   = x_plot;
            pend_y_nx   = y_plot;
            pend_sel_nx = select;
          end else begin
            pend_vld_nx = 1'b0;
          end
        end else if (enable) begin
          act_x_nx   = x_plot;
          act_y_nx   = y_plot;
          act_sel_nx = select;
          state_nx   = DRAW;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output stage: registered from the next-state values so plot tracks the DRAW state exactly.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= IDLE;
      pend_vld <= 1'b0;
      cx       <= 4'd0;
      cy       <= 4'd0;
      vga_x    <= 8'd0;
      vga_y    <= 7'd0;
      colour   <= 3'b000;
      plot     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      pend_vld <= pend_vld_nx;
      cx       <= cx_nx;
      cy       <= cy_nx;
      plot     <= (state_nx == DRAW);
      busy     <= (state_nx != IDLE);
      done     <= (state_nx == DONE);
      overflow <= drop;
      if (state_nx == DRAW) begin
        vga_x  <= act_x_nx + 8'(cx_nx);
        vga_y  <= act_y_nx + 7'(cy_nx);
        colour <= pixel_colour(cx_nx, cy_nx, act_sel_nx);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      act_x    <= act_x_nx;
      act_y    <= act_y_nx;
      act_sel  <= act_sel_nx;
      pend_x   <= pend_x_nx;
      pend_y   <= pend_y_nx;
      pend_sel <= pend_sel_nx;
    end
  end

endmodule

// File: tb/tb_cell_drawer.sv
// tb_cell_drawer: randomized self-checking bench for cell_drawer against a pixel-stream model.
// Honours CELL_DRAWER_GRID_EN to select the 13x13 cell geometry.
module tb_cell_drawer;

`ifdef CELL_DRAWER_GRID_EN
  localparam int N = 13;
`else
  localparam int N = 12;
`endif
  localparam int NN = N * N;
  localparam logic [2:0] BG = 3'b010;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] x_plot = 8'd0;
  logic [6:0] y_plot = 7'd0;
  logic [1:0] select = 2'd0;
  logic       enable = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot, busy, done, overflow;

  int checks = 0;
  int failures = 0;
  pix_t seen[$];

  cell_drawer dut (
    .clock(clock), .resetn(resetn), .x_plot(x_plot), .y_plot(y_plot),
    .select(select), .enable(enable), .vga_x(vga_x), .vga_y(vga_y),
    .colour(colour), .plot(plot), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference colour of local pixel (cx, cy) taken straight from the cell rules.
  function automatic logic [2:0] exp_colour(int cx, int cy, int sel);
    bit disk;
    if (cx >= 12 || cy >= 12) return 3'b000;
    disk = (cx >= 2 && cx <= 9 && cy >= 2 && cy <= 9) &&
           !((cx == 2 || cx == 9) && (cy == 2 || cy == 9));
    if (disk && sel == 2) return 3'b000;
    if (disk && sel == 3) return 3'b111;
    return BG;
  endfunction

  function automatic pix_t seen_at(int idx);
    if (idx < seen.size()) return seen[idx];
    return '1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [7:0] x, input logic [6:0] y, input logic [1:0] sel);
    x_plot = x;
    y_plot = y;
    select = sel;
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  // Starts with the cell's first pixel visible; returns with the done cycle visible.
  task automatic expect_cell(input logic [7:0] x, input logic [6:0] y, input logic [1:0] sel,
                             output int bad, output int npix, output bit got_done);
    pix_t exp_q[$];
    pix_t e, a;
    bad = 0;
    npix = 0;
    got_done = 0;
    seen.delete();
    for (int cy = 0; cy < N; cy++)
      for (int cx = 0; cx < N; cx++) begin
        e.x = 8'((int'(x) + cx) % 256);
        e.y = 7'((int'(y) + cy) % 128);
        e.c = exp_colour(cx, cy, int'(sel));
        exp_q.push_back(e);
      end
    for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
      a = {vga_x, vga_y, colour};
      if (plot && done) bad++;
      if (plot) begin
        seen.push_back(a);
        npix++;
        if (exp_q.size() == 0) bad++;
        else begin
          e = exp_q.pop_front();
          if (a !== e) bad++;
        end
      end else if (done) begin
        got_done = 1;
        if (npix > 0 && a !== seen[$]) bad++;
      end else begin
        bad++;
      end
      if (!got_done) tick();
    end
    bad += exp_q.size();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    enable = 1'b1;
    x_plot = 8'd33;
    y_plot = 7'd44;
    select = 2'd3;
    repeat (3) tick();
    checks++;
    if ({vga_x, vga_y, colour, plot, busy, done, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b ovf=%b, want all 0",
               vga_x, vga_y, colour, plot, busy, done, overflow);
    end
    resetn = 1'b1;
    enable = 1'b0;
    tick();
    checks++;
    if ({busy, plot} !== 2'b00) begin
      failures++;
      $display("FAIL reset_enable_ignored: got busy=%b plot=%b, want 0 0", busy, plot);
    end
  endtask

  task automatic test_basic();
    int bad, npix;
    bit gd;
    issue(8'd9, 7'd9, 2'd0);
    expect_cell(8'd9, 7'd9, 2'd0, bad, npix, gd);
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL basic_stream: bad=%0d want 0", bad); end
    checks++;
    if (npix !== NN) begin failures++; $display("FAIL basic_count: got %0d want %0d", npix, NN); end
    checks++;
    if (gd !== 1'b1) begin failures++; $display("FAIL basic_done: got %b want 1", gd); end
    checks++;
    if (seen_at(0) !== pix_t'({8'd9, 7'd9, BG})) begin
      failures++; $display("FAIL basic_first: got %h want %h", seen_at(0), pix_t'({8'd9, 7'd9, BG}));
    end
    checks++;
    if (seen_at(NN-1).x !== 8'(9 + N - 1) || seen_at(NN-1).y !== 7'(9 + N - 1)) begin
      failures++;
      $display("FAIL basic_last: got (%0d,%0d) want (%0d,%0d)", seen_at(NN-1).x, seen_at(NN-1).y,
               9 + N - 1, 9 + N - 1);
    end
    tick();
    checks++;
    if ({busy, plot, done} !== 3'b000 || vga_x !== 8'(9 + N - 1) || vga_y !== 7'(9 + N - 1)) begin
      failures++;
      $display("FAIL basic_idle_hold: got busy=%b plot=%b done=%b x=%0d y=%0d want 0 0 0 %0d %0d",
               busy, plot, done, vga_x, vga_y, 9 + N - 1, 9 + N - 1);
    end
  endtask

  task automatic test_disk();
    int bad, npix;
    bit gd;
    issue(8'd22, 7'd9, 2'd2);
    expect_cell(8'd22, 7'd9, 2'd2, bad, npix, gd);
    checks++;
    if (bad !== 0 || npix !== NN || !gd) begin
      failures++; $display("FAIL black_stream: bad=%0d npix=%0d done=%b want 0 %0d 1", bad, npix, gd, NN);
    end
    checks++;
    if (seen_at(2*N+2) !== pix_t'({8'd24, 7'd11, BG})) begin
      failures++; $display("FAIL black_corner: got %h want %h", seen_at(2*N+2), pix_t'({8'd24, 7'd11, BG}));
    end
    checks++;
    if (seen_at(2*N+3) !== pix_t'({8'd25, 7'd11, 3'b000})) begin
      failures++; $display("FAIL black_disk: got %h want %h", seen_at(2*N+3), pix_t'({8'd25, 7'd11, 3'b000}));
    end
    tick();
    issue(8'd22, 7'd9, 2'd3);
    expect_cell(8'd22, 7'd9, 2'd3, bad, npix, gd);
    checks++;
    if (bad !== 0 || npix !== NN || !gd) begin
      failures++; $display("FAIL white_stream: bad=%0d npix=%0d done=%b want 0 %0d 1", bad, npix, gd, NN);
    end
    checks++;
    if (seen_at(2*N+3) !== pix_t'({8'd25, 7'd11, 3'b111})) begin
      failures++; $display("FAIL white_disk: got %h want %h", seen_at(2*N+3), pix_t'({8'd25, 7'd11, 3'b111}));
    end
    tick();
  endtask

  task automatic test_wrap();
    int bad, npix;
    bit gd;
    issue(8'd250, 7'd120, 2'd1);
    expect_cell(8'd250, 7'd120, 2'd1, bad, npix, gd);
    checks++;
    if (bad !== 0 || npix !== NN || !gd) begin
      failures++; $display("FAIL wrap_stream: bad=%0d npix=%0d done=%b want 0 %0d 1", bad, npix, gd, NN);
    end
    checks++;
    if (seen_at(5) !== pix_t'({8'd255, 7'd120, BG}) || seen_at(6) !== pix_t'({8'd0, 7'd120, BG})) begin
      failures++; $display("FAIL wrap_x: got %h %h want x 255 then 0", seen_at(5), seen_at(6));
    end
    checks++;
    if (seen_at(7*N) !== pix_t'({8'd250, 7'd127, BG}) || seen_at(8*N) !== pix_t'({8'd250, 7'd0, BG})) begin
      failures++; $display("FAIL wrap_y: got %h %h want y 127 then 0", seen_at(7*N), seen_at(8*N));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int bad_a, np_a, bad_b, np_b;
    bit gd_a, gd_b;
    issue(8'd10, 7'd20, 2'd2);
    fork
      expect_cell(8'd10, 7'd20, 2'd2, bad_a, np_a, gd_a);
      begin
        x_plot = 8'd40; y_plot = 7'd50; select = 2'd3; enable = 1'b1;
        tick();
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_b_no_ovf: got %b want 0", overflow); end
        x_plot = 8'd99; y_plot = 7'd99; select = 2'd2;
        tick();
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL b2b_c_ovf: got %b want 1", overflow); end
        enable = 1'b0;
        tick();
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_ovf_pulse: got %b want 0", overflow); end
      end
    join
    checks++;
    if (bad_a !== 0 || np_a !== NN || !gd_a) begin
      failures++; $display("FAIL b2b_a: bad=%0d npix=%0d done=%b want 0 %0d 1", bad_a, np_a, gd_a, NN);
    end
    tick();
    expect_cell(8'd40, 7'd50, 2'd3, bad_b, np_b, gd_b);
    checks++;
    if (bad_b !== 0 || np_b !== NN || !gd_b) begin
      failures++; $display("FAIL b2b_b: bad=%0d npix=%0d done=%b want 0 %0d 1", bad_b, np_b, gd_b, NN);
    end
    tick();
    checks++;
    if ({busy, plot} !== 2'b00) begin
      failures++; $display("FAIL b2b_c_dropped: got busy=%b plot=%b want 0 0", busy, plot);
    end
  endtask

  task automatic test_done_refill();
    int bad, npix;
    bit gd;
    issue(8'd1, 7'd2, 2'd3);
    fork
      expect_cell(8'd1, 7'd2, 2'd3, bad, npix, gd);
      begin
        repeat (20) tick();
        x_plot = 8'd60; y_plot = 7'd70; select = 2'd2; enable = 1'b1;
        tick();
        enable = 1'b0;
      end
    join
    checks++;
    if (bad !== 0 || npix !== NN || !gd) begin
      failures++; $display("FAIL refill_a: bad=%0d npix=%0d done=%b want 0 %0d 1", bad, npix, gd, NN);
    end
    x_plot = 8'd130; y_plot = 7'd5; select = 2'd0; enable = 1'b1;
    tick();
    enable = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL refill_no_ovf: got %b want 0", overflow); end
    expect_cell(8'd60, 7'd70, 2'd2, bad, npix, gd);
    checks++;
    if (bad !== 0 || npix !== NN || !gd) begin
      failures++; $display("FAIL refill_b: bad=%0d npix=%0d done=%b want 0 %0d 1", bad, npix, gd, NN);
    end
    tick();
    expect_cell(8'd130, 7'd5, 2'd0, bad, npix, gd);
    checks++;
    if (bad !== 0 || npix !== NN || !gd) begin
      failures++; $display("FAIL refill_d: bad=%0d npix=%0d done=%b want 0 %0d 1", bad, npix, gd, NN);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int bad, npix, stray;
    bit gd;
    logic [7:0] rx;
    logic [6:0] ry;
    logic [1:0] rs;
    issue(8'd70, 7'd30, 2'd2);
    repeat (50) tick();
    checks++;
    if (plot !== 1'b1 || vga_x !== 8'(70 + 50 % N) || vga_y !== 7'(30 + 50 / N)) begin
      failures++; $display("FAIL midreset_pixel50: got plot=%b x=%0d y=%0d want 1 %0d %0d",
                           plot, vga_x, vga_y, 70 + 50 % N, 30 + 50 / N);
    end
    resetn = 1'b0;
    enable = 1'b1;
    tick();
    checks++;
    if ({plot, busy, done, overflow} !== 4'b0000) begin
      failures++; $display("FAIL midreset_abort: got plot=%b busy=%b done=%b ovf=%b want 0 0 0 0",
                           plot, busy, done, overflow);
    end
    resetn = 1'b1;
    enable = 1'b0;
    stray = 0;
    repeat (N * N + 4) begin
      tick();
      if (done || plot || busy) stray++;
    end
    checks++;
    if (stray !== 0) begin failures++; $display("FAIL midreset_quiet: got %0d active cycles want 0", stray); end
    rx = 8'($urandom_range(0, 255));
    ry = 7'($urandom_range(0, 127));
    rs = 2'($urandom_range(0, 3));
    issue(rx, ry, rs);
    expect_cell(rx, ry, rs, bad, npix, gd);
    checks++;
    if (bad !== 0 || npix !== NN || !gd) begin
      failures++; $display("FAIL midreset_next: bad=%0d npix=%0d done=%b want 0 %0d 1", bad, npix, gd, NN);
    end
    tick();
  endtask

  task automatic test_random();
    int bad, npix;
    bit gd;
    logic [7:0] rx;
    logic [6:0] ry;
    logic [1:0] rs;
    rx = 8'($urandom_range(0, 255));
    ry = 7'($urandom_range(0, 127));
    rs = 2'($urandom_range(0, 3));
    issue(rx, ry, rs);
    for (int k = 0; k < 6; k++) begin
      expect_cell(rx, ry, rs, bad, npix, gd);
      checks++;
      if (bad !== 0 || npix !== NN || !gd) begin
        failures++; $display("FAIL random_cell%0d: bad=%0d npix=%0d done=%b want 0 %0d 1", k, bad, npix, gd, NN);
      end
      rx = 8'($urandom_range(0, 255));
      ry = 7'($urandom_range(0, 127));
      rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL random_idle%0d: busy=%b want 0", k, busy); end
      end
      issue(rx, ry, rs);
    end
    expect_cell(rx, ry, rs, bad, npix, gd);
    checks++;
    if (bad !== 0 || npix !== NN || !gd) begin
      failures++; $display("FAIL random_last: bad=%0d npix=%0d done=%b want 0 %0d 1", bad, npix, gd, NN);
    end
    tick();
  endtask

`ifdef CELL_DRAWER_GRID_EN
  task automatic test_grid();
    int bad, npix, grid_px, grid_bad;
    bit gd;
    issue(8'd100, 7'd50, 2'd3);
    expect_cell(8'd100, 7'd50, 2'd3, bad, npix, gd);
    checks++;
    if (bad !== 0 || npix !== 169 || !gd) begin
      failures++; $display("FAIL grid_stream: bad=%0d npix=%0d done=%b want 0 169 1", bad, npix, gd);
    end
    grid_px = 0;
    grid_bad = 0;
    for (int i = 0; i < seen.size(); i++)
      if (i % 13 == 12 || i / 13 == 12) begin
        grid_px++;
        if (seen[i].c !== 3'b000) grid_bad++;
      end
    checks++;
    if (grid_px !== 25 || grid_bad !== 0) begin
      failures++; $display("FAIL grid_pixels: got %0d grid px, %0d wrong colour; want 25, 0", grid_px, grid_bad);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_disk();
    test_wrap();
    test_back_to_back();
    test_done_refill();
    test_reset_mid();
    test_random();
`ifdef CELL_DRAWER_GRID_EN
    test_grid();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cell_drawer.md
CELL_DRAWER -- requirements
Module: cell_drawer

Interface
REQ-001 SHALL expose parameter BG_COLOUR, default 3'b010: 3-bit RGB colour for empty-cell background.
REQ-002 SHALL expose port clock  input  1: single system clock; every register updates on its rising edge.
REQ-003 SHALL expose port resetn  input  1: reset, synchronous, active-low.
REQ-004 SHALL expose port x_plot  input  8: cell top-left pixel X from the board plot stream.
REQ-005 SHALL expose port y_plot  input  7: cell top-left pixel Y from the board plot stream.
REQ-006 SHALL expose port select  input  2: cell content; 0/1 empty, 2 black disk, 3 white disk.
REQ-007 SHALL expose port enable  input  1: one-cycle strobe; x_plot, y_plot and select are valid in that cycle.
REQ-008 SHALL expose port vga_x  output  8: pixel X to the VGA adapter.
REQ-009 SHALL expose port vga_y  output  7: pixel Y to the VGA adapter.
REQ-010 SHALL expose port colour  output  3: pixel RGB to the VGA adapter.
REQ-011 SHALL expose port plot  output  1: pixel write strobe; vga_x, vga_y and colour are valid when high.
REQ-012 SHALL expose port busy  output  1: high while state is not IDLE.
REQ-013 SHALL expose port done  output  1: one-cycle pulse after the last pixel of a cell.
REQ-014 SHALL expose port overflow  output  1: one-cycle pulse when a request is dropped.

Function
REQ-015 SHALL implement states IDLE, DRAW, DONE; all outputs registered.
REQ-016 SHALL capture x_plot, y_plot and select into the active registers when enable is high in IDLE, and enter DRAW on the next edge.
REQ-017 SHALL emit one pixel per cycle in DRAW, row-major over local (cx, cy) with cx, cy running 0..N-1, where N is 12 (REQ-030 changes this); plot is high on every DRAW cycle; first pixel appears the cycle after capture.
REQ-018 SHALL drive vga_x = x_plot+cx truncated to 8 bits and vga_y = y_plot+cy truncated to 7 bits (wrap, no saturation).
REQ-019 SHALL classify a pixel as disk when cx, cy are both in 2..9 and the pixel is not one of the four corners (2,2), (2,9), (9,2), (9,9).
REQ-020 SHALL output colour 3'b000 for disk pixels with select=2, 3'b111 for disk pixels with select=3, and BG_COLOUR for all other pixels, including every pixel of a select=0/1 cell.
REQ-021 SHALL enter DONE after the last pixel (cx=cy=N-1); in DONE, done=1 and plot=0 for exactly one cycle.
REQ-022 SHALL capture a request arriving while state is DRAW or DONE into a one-entry pending buffer when that buffer is empty.
REQ-023 SHALL, in DONE, load the pending entry into active and go to DRAW if pending is valid, else capture enable if high and go to DRAW, else go to IDLE.
REQ-024 SHALL, in DONE with pending valid and enable high, move pending to active and capture the new request into pending.
REQ-025 SHALL drop a request arriving while the pending buffer is full, except per REQ-024, pulse overflow for one cycle, and leave the active and pending contents unchanged.
REQ-026 SHALL hold vga_x, vga_y and colour at their last values when plot is low.

Reset
REQ-027 SHALL, when resetn is low at a rising edge, force IDLE, clear pending-valid, and set vga_x, vga_y, colour, plot, busy, done and overflow to 0.
REQ-028 SHALL abort a cell mid-draw on reset with no further pixels, and SHALL NOT emit a done pulse for the aborted cell.
REQ-029 SHALL ignore enable in any cycle where resetn is low.

Configuration
REQ-030 SHALL, with macro CELL_DRAWER_GRID_EN defined, use N=13: the extra row cy=12 and column cx=12 are grid pixels of colour 3'b000, giving 169 pixels per cell; the disk rule is unchanged.
REQ-031 SHALL, without CELL_DRAWER_GRID_EN, use N=12 and emit 144 pixels per cell with no grid pixels.

Verification
REQ-032 SHALL cover: reset, then enable with x_plot=9, y_plot=9, select=0 -> 144 plot cycles, first pixel (9,9,BG_COLOUR), last pixel (20,20), done one cycle after the last pixel.
REQ-033 SHALL cover: select=2 at (22,9) -> pixel (24,11) is BG_COLOUR, pixel (25,11) is 3'b000; select=3 -> pixel (25,11) is 3'b111.
REQ-034 SHALL cover: x_plot=250, y_plot=120 -> vga_x wraps 255 to 0 and vga_y wraps 127 to 0.
REQ-035 SHALL cover: three back-to-back strobes A, B, C during one draw -> B pending, C dropped with overflow=1, then B draws starting the cycle after A's done.
REQ-036 SHALL cover: resetn low at pixel 50 -> plot=0, busy=0 next cycle, no done pulse, and the next enable draws normally.
REQ-037 SHALL cover: with CELL_DRAWER_GRID_EN defined -> 169 pixels per cell, and every pixel with cx=12 or cy=12 is 3'b000.
